// File: rtl/spi_slave_if.sv
// Bus bundle between the SPI slave and its surroundings: the four SPI pins
// plus the ALU-facing operand/result words.
// Optional macro SPI_SLAVE_OPERAND_VALID_EN adds the operand_valid strobe.
interface spi_slave_if #(
  parameter int DATA_W = 32
);
  logic                  SPI_CLK;
  logic                  SPI_PICO;
  logic                  SPI_CS;
  logic                  SPI_POCI;
  logic [2*DATA_W-1:0]   alu_results;
  logic [DATA_W-1:0]     operand1;
  logic [DATA_W-1:0]     operand2;
`ifdef SPI_SLAVE_OPERAND_VALID_EN
  logic                  operand_valid;

  modport slave (
    input  SPI_CLK, SPI_PICO, SPI_CS, alu_results,
    output SPI_POCI, operand1, operand2, operand_valid
  );

  modport master (
    output SPI_CLK, SPI_PICO, SPI_CS, alu_results,
    input  SPI_POCI, operand1, operand2, operand_valid
  );
`else
  modport slave (
    input  SPI_CLK, SPI_PICO, SPI_CS, alu_results,
    output SPI_POCI, operand1, operand2
  );

  modport master (
    output SPI_CLK, SPI_PICO, SPI_CS, alu_results,
    input  SPI_POCI, operand1, operand2
  );
`endif
endinterface

// File: rtl/spi_slave.sv
// SPI mode 0 slave, oversampled in the clk domain. Receives a 2*DATA_W bit
// operand frame (MSB first) and returns the latched ALU result word in the
// same full-duplex transfer.
// Optional macro SPI_SLAVE_OPERAND_VALID_EN adds a one-cycle operand_valid
// strobe coincident with the operand update.
module spi_slave #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  localparam int                FRAME_W  = 2 * DATA_W;
  localparam int                CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_W - 1);

  // IDLE: no frame; SHIFT: collecting bits; DONE: full frame seen, extra
  // edges ignored until CS goes high again.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] pico_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_s;
  logic                   cs_s;
  logic                   pico_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_fall;

  logic                   rx_shift;
  logic                   tx_shift;
  logic                   frame_done;
  logic                   load_q;

  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_W-1:0]     rx_q;
  logic [FRAME_W-1:0]     tx_q;
  logic                   poci_q;
  logic [DATA_W-1:0]      op1_q;
  logic [DATA_W-1:0]      op2_q;

  // PICO is taken from the same stage as SCK so data and clock line up.
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign pico_s   = pico_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;

  // Synchronise the SPI pins and keep one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      pico_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.SPI_CLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.SPI_CS};
      pico_sync <= {pico_sync[SYNC_STAGES-2:0], bus.SPI_PICO};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and shift strobes; a CS falling edge wins over any SCK edge.
  always_comb begin
    state_d    = state_q;
    rx_shift   = 1'b0;
    tx_shift   = 1'b0;
    frame_done = 1'b0;
    if (cs_s) begin
      state_d = IDLE;
    end else if (cs_fall) begin
      state_d = SHIFT;
    end else begin
      tx_shift = (state_q != IDLE) && sck_fall;
      if (state_q == SHIFT && sck_rise) begin
        rx_shift = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          frame_done = 1'b1;
          state_d    = DONE;
        end
      end
    end
  end

  // Receive side: bit counter, rx shift register and completion strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      rx_q    <= '0;
      load_q  <= 1'b0;
    end else begin
      load_q <= frame_done;
      if (cs_s || cs_fall) begin
        bit_cnt <= '0;
      end else if (rx_shift) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (rx_shift) begin
        rx_q <= {rx_q[FRAME_W-2:0], pico_s};
      end
    end
  end

  // Transmit side: latch the result at frame start, shift on SCK falls;
  // zero fill makes POCI drop to 0 once every bit has gone out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q   <= '0;
      poci_q <= 1'b0;
    end else if (cs_s) begin
      poci_q <= 1'b0;
    end else if (cs_fall) begin
      tx_q   <= bus.alu_results;
      poci_q <= bus.alu_results[FRAME_W-1];
    end else if (tx_shift) begin
      tx_q   <= {tx_q[FRAME_W-2:0], 1'b0};
      poci_q <= tx_q[FRAME_W-2];
    end
  end

  // Publish both operands together one cycle after the last bit arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q <= '0;
      op2_q <= '0;
    end else if (load_q) begin
      op1_q <= rx_q[FRAME_W-1:DATA_W];
      op2_q <= rx_q[DATA_W-1:0];
    end
  end

  assign bus.SPI_POCI = poci_q;
  assign bus.operand1 = op1_q;
  assign bus.operand2 = op2_q;

`ifdef SPI_SLAVE_OPERAND_VALID_EN
  logic valid_q;

  // Strobe aligned with the operand register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_q;
    end
  end

  assign bus.operand_valid = valid_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: an SPI mode 0 host model driving
// 10 MHz SCK against a 100 MHz clk, checked against a frame-level model.
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_op1 = 32'h0;
  logic [31:0] model_op2 = 32'h0;

  spi_slave_if #(.DATA_W(32)) bus ();

  spi_slave #(
    .DATA_W      (32),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef SPI_SLAVE_OPERAND_VALID_EN
  int valid_pulses = 0;

  // Every strobe cycle must already show the frame's operands.
  always @(negedge clk) begin
    if (bus.operand_valid === 1'b1) begin
      valid_pulses++;
      checks++;
      if (bus.operand1 !== model_op1 || bus.operand2 !== model_op2) begin
        errors++;
        $display("[TB] FAIL valid_coincident: got %h_%h expected %h_%h",
                 bus.operand1, bus.operand2, model_op1, model_op2);
      end
    end
  end
`endif

  // What the host shift register holds after n sampled bits.
  function automatic logic [63:0] expect_host_rx(input logic [63:0] alu, input int n);
    if (n >= 64) return alu << (n - 64);
    return alu >> (64 - n);
  endfunction

  // Host side of one transfer; PICO changes on SCK fall, POCI sampled at rise.
  task automatic spi_xfer(input logic [63:0] frame, input int nbits,
                          input bit change_alu, input bit keep_low,
                          output logic [63:0] host_rx,
                          output logic [31:0] op1_at, output logic [31:0] op2_at);
    host_rx = 64'h0;
    op1_at  = bus.operand1;
    op2_at  = bus.operand2;
    @(negedge clk);
    bus.SPI_CS   = 1'b0;
    bus.SPI_PICO = frame[63];
    #100;
    for (int i = 0; i < nbits; i++) begin
      bus.SPI_CLK = 1'b1;
      host_rx = {host_rx[62:0], bus.SPI_POCI};
      #50;
      bus.SPI_CLK = 1'b0;
      if (i == 63) begin
        op1_at = bus.operand1;
        op2_at = bus.operand2;
      end
      if (change_alu && i == 10) bus.alu_results = {$urandom, $urandom};
      if (i + 1 < 64) bus.SPI_PICO = frame[62 - i];
      else            bus.SPI_PICO = 1'($urandom);
      #50;
    end
    if (!keep_low) begin
      #50;
      bus.SPI_CS   = 1'b1;
      bus.SPI_PICO = 1'b0;
      #100;
    end
  endtask

  task automatic test_reset();
    bus.alu_results = 64'hA5A5_5A5A_0F0F_F0F0;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.operand1 !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_op1: got %h expected 00000000", bus.operand1);
    end
    checks++;
    if (bus.operand2 !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_op2: got %h expected 00000000", bus.operand2);
    end
    checks++;
    if (bus.SPI_POCI !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_poci: got %b expected 0", bus.SPI_POCI);
    end
`ifdef SPI_SLAVE_OPERAND_VALID_EN
    checks++;
    if (bus.operand_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.operand_valid);
    end
`endif
  endtask

  // Runs one frame and checks host data, operands and strobe count.
  task automatic run_frame(input string name, input logic [63:0] alu,
                           input logic [63:0] frame, input int nbits,
                           input bit change_alu);
    logic [63:0] host_rx;
    logic [31:0] op1_at, op2_at;
    logic [63:0] exp_rx;
`ifdef SPI_SLAVE_OPERAND_VALID_EN
    int before;
    before = valid_pulses;
`endif
    bus.alu_results = alu;
    exp_rx = expect_host_rx(alu, nbits);
    if (nbits >= 64) begin
      model_op1 = frame[63:32];
      model_op2 = frame[31:0];
    end
    spi_xfer(frame, nbits, change_alu, 1'b0, host_rx, op1_at, op2_at);
    checks++;
    if (host_rx !== exp_rx) begin
      errors++; $display("[TB] FAIL %s_host_rx: got %h expected %h", name, host_rx, exp_rx);
    end
    if (nbits >= 64) begin
      checks++;
      if (op1_at !== model_op1 || op2_at !== model_op2) begin
        errors++; $display("[TB] FAIL %s_latency: got %h_%h expected %h_%h",
                           name, op1_at, op2_at, model_op1, model_op2);
      end
    end
    checks++;
    if (bus.operand1 !== model_op1 || bus.operand2 !== model_op2) begin
      errors++; $display("[TB] FAIL %s_operands: got %h_%h expected %h_%h",
                         name, bus.operand1, bus.operand2, model_op1, model_op2);
    end
    checks++;
    if (bus.SPI_POCI !== 1'b0) begin
      errors++; $display("[TB] FAIL %s_idle_poci: got %b expected 0", name, bus.SPI_POCI);
    end
`ifdef SPI_SLAVE_OPERAND_VALID_EN
    checks++;
    if (valid_pulses - before !== ((nbits >= 64) ? 1 : 0)) begin
      errors++; $display("[TB] FAIL %s_valid_pulses: got %0d expected %0d",
                         name, valid_pulses - before, (nbits >= 64) ? 1 : 0);
    end
`endif
  endtask

  task automatic test_full_frame();
    run_frame("full", 64'hBEEF_DEAD_DEAD_BEEF, 64'hBEEF_DEAD_BEEF_DEAD, 64, 1'b0);
  endtask

  task automatic test_partial_frame();
    run_frame("partial", 64'hCAFE_F00D_1234_5678, 64'h1234_5678_0000_0000, 32, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_first", 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000, 64, 1'b0);
    run_frame("b2b_second", 64'h0123_4567_89AB_CDEF, 64'h3F80_0000_4000_0000, 64, 1'b0);
  endtask

  task automatic test_overlength();
    run_frame("overlength", {$urandom, $urandom}, {$urandom, $urandom},
              64 + int'($urandom_range(8, 1)), 1'b0);
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 6; k++) begin
      run_frame("random", {$urandom, $urandom}, {$urandom, $urandom}, 64, k[0]);
    end
  endtask

  task automatic test_idle_sck();
    @(negedge clk);
    bus.SPI_CS = 1'b1;
    for (int i = 0; i < 70; i++) begin
      bus.SPI_PICO = 1'($urandom);
      bus.SPI_CLK  = 1'b1;
      #50;
      bus.SPI_CLK  = 1'b0;
      #50;
    end
    checks++;
    if (bus.operand1 !== model_op1 || bus.operand2 !== model_op2) begin
      errors++; $display("[TB] FAIL idle_sck_operands: got %h_%h expected %h_%h",
                         bus.operand1, bus.operand2, model_op1, model_op2);
    end
    checks++;
    if (bus.SPI_POCI !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_sck_poci: got %b expected 0", bus.SPI_POCI);
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [63:0] host_rx;
    logic [31:0] op1_at, op2_at;
    bus.alu_results = 64'h7777_8888_9999_AAAA;
    spi_xfer(64'h5555_6666_7777_8888, 20, 1'b0, 1'b1, host_rx, op1_at, op2_at);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_op1 = 32'h0;
    model_op2 = 32'h0;
    @(negedge clk);
    checks++;
    if (bus.operand1 !== 32'h0 || bus.operand2 !== 32'h0) begin
      errors++; $display("[TB] FAIL midreset_operands: got %h_%h expected 00000000_00000000",
                         bus.operand1, bus.operand2);
    end
    bus.SPI_CS = 1'b1;
    #100;
    checks++;
    if (bus.SPI_POCI !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_poci: got %b expected 0", bus.SPI_POCI);
    end
    run_frame("after_reset", 64'h7777_8888_9999_AAAA, 64'h1111_1111_2222_2222, 64, 1'b0);
  endtask

  initial begin
    bus.SPI_CLK     = 1'b0;
    bus.SPI_CS      = 1'b1;
    bus.SPI_PICO    = 1'b0;
    bus.alu_results = 64'h0;
    test_reset();
    test_full_frame();
    test_partial_frame();
    test_back_to_back();
    test_idle_sck();
    test_overlength();
    test_random_frames();
    test_mid_frame_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
